// File: rtl/mesi_isc_broad_pkg.sv
// Shared definitions for the N-CPU MESI broadcast unit: cbus command codes,
// broadcast types, FSM states and the latched request entry.
package mesi_isc_broad_pkg;

  localparam logic [2:0] CBUS_CMD_NOP      = 3'd0;
  localparam logic [2:0] CBUS_CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CBUS_CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CBUS_CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CBUS_CMD_EN_RD    = 3'd4;

  localparam logic [1:0] BROAD_TYPE_WR = 2'd1;
  localparam logic [1:0] BROAD_TYPE_RD = 2'd2;

  // Entry fields are sized for the largest supported configuration; the top
  // level zero-extends its parameter-width fields into them.
  localparam int ENT_ADDR_W = 64;
  localparam int ENT_TYPE_W = 2;
  localparam int ENT_CPU_W  = 8;
  localparam int ENT_ID_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_ENABLE,
    ST_RETIRE
  } broad_state_t;

  typedef struct packed {
    logic [ENT_ADDR_W-1:0] addr;
    logic [ENT_TYPE_W-1:0] btype;
    logic [ENT_CPU_W-1:0]  cpu_id;
    logic [ENT_ID_W-1:0]   id;
  } broad_entry_t;

endpackage

// File: rtl/mesi_isc_broad_fifo.sv
// Parametrised synchronous FIFO; a push while full is dropped, and fullness is
// judged before any same-cycle pop.
module mesi_isc_broad_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_W-1:0]     i_data,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mesi_isc_broad_nc.sv
// N-CPU MESI broadcast unit: queues requests, snoops every non-originating CPU,
// then enables the originator. Optional macro MESI_ISC_BROAD_ERR_EN adds err_o.
module mesi_isc_broad_nc
  import mesi_isc_broad_pkg::*;
#(
  parameter int CPU_COUNT        = 4,
  parameter int CPU_ID_WIDTH     = 2,
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int FIFO_DEPTH       = 4,
  parameter int FIFO_DEPTH_LOG2  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CPU_COUNT-1:0]                cbus_ack_array_i,
  input  logic                                broad_fifo_wr_i,
  input  logic [ADDR_WIDTH-1:0]               broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]         broad_type_i,
  input  logic [CPU_ID_WIDTH-1:0]             broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]           broad_id_i,
  output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
  output logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
  output logic                                fifo_status_full_o,
  output logic [FIFO_DEPTH_LOG2:0]            fifo_count_o,
  output logic                                broad_done_o,
  output logic [BROAD_ID_WIDTH-1:0]           broad_done_id_o,
  output logic                                busy_o
`ifdef MESI_ISC_BROAD_ERR_EN
  ,
  output logic [1:0]                          err_o
`endif
);

  localparam int ENTRY_W = ADDR_WIDTH + BROAD_TYPE_WIDTH + CPU_ID_WIDTH + BROAD_ID_WIDTH;

  logic [ENTRY_W-1:0]          w_push_data;
  logic [ENTRY_W-1:0]          w_pop_data;
  logic                        w_empty;
  logic                        w_pop;
  logic [BROAD_TYPE_WIDTH-1:0] w_head_type;
  logic                        w_head_valid;
  broad_entry_t                w_head;
  broad_entry_t                r_entry;
  broad_state_t                r_state;
  broad_state_t                w_state_nxt;
  logic [CPU_COUNT-1:0]        r_mask;
  logic [CPU_COUNT-1:0]        w_mask_nxt;
  logic [CPU_COUNT-1:0]        w_orig_sel;
  logic                        w_is_wr;

  assign w_push_data = {broad_addr_i, broad_type_i, broad_cpu_id_i, broad_id_i};

  mesi_isc_broad_fifo #(
    .DATA_W     (ENTRY_W),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (broad_fifo_wr_i),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (w_pop_data),
    .o_full  (fifo_status_full_o),
    .o_empty (w_empty),
    .o_count (fifo_count_o)
  );

  assign w_head_type   = w_pop_data[BROAD_ID_WIDTH+CPU_ID_WIDTH +: BROAD_TYPE_WIDTH];
  assign w_head.addr   = ENT_ADDR_W'(w_pop_data[ENTRY_W-1 -: ADDR_WIDTH]);
  assign w_head.btype  = ENT_TYPE_W'(w_head_type);
  assign w_head.cpu_id = ENT_CPU_W'(w_pop_data[BROAD_ID_WIDTH +: CPU_ID_WIDTH]);
  assign w_head.id     = ENT_ID_W'(w_pop_data[BROAD_ID_WIDTH-1:0]);

  assign w_head_valid = ((w_head_type == BROAD_TYPE_WIDTH'(BROAD_TYPE_WR)) ||
                         (w_head_type == BROAD_TYPE_WIDTH'(BROAD_TYPE_RD))) &&
                        (w_head.cpu_id < ENT_CPU_W'(CPU_COUNT));

  assign w_orig_sel = CPU_COUNT'(1) << r_entry.cpu_id;
  assign w_is_wr    = (r_entry.btype == BROAD_TYPE_WR);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          // Invalid entries skip the cbus entirely and just retire.
          if (w_head_valid) begin
            w_mask_nxt  = ~(CPU_COUNT'(1) << w_head.cpu_id);
            w_state_nxt = ST_SNOOP;
          end else begin
            w_mask_nxt  = '0;
            w_state_nxt = ST_RETIRE;
          end
        end
      end
      ST_SNOOP: begin
        w_mask_nxt = r_mask & ~cbus_ack_array_i;
        if (w_mask_nxt == '0) w_state_nxt = ST_ENABLE;
      end
      ST_ENABLE: begin
        if (|(cbus_ack_array_i & w_orig_sel)) w_state_nxt = ST_RETIRE;
      end
      ST_RETIRE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_entry <= w_head;
  end

  always_comb begin
    cbus_cmd_array_o = '0;
    for (int i = 0; i < CPU_COUNT; i++) begin
      if (r_state == ST_SNOOP && r_mask[i])
        cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
          CBUS_CMD_WIDTH'(w_is_wr ? CBUS_CMD_WR_SNOOP : CBUS_CMD_RD_SNOOP);
      else if (r_state == ST_ENABLE && w_orig_sel[i])
        cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
          CBUS_CMD_WIDTH'(w_is_wr ? CBUS_CMD_EN_WR : CBUS_CMD_EN_RD);
    end
  end

  // Latched data is never reset, so every data output is gated by state.
  assign busy_o          = (r_state != ST_IDLE);
  assign cbus_addr_o     = busy_o ? ADDR_WIDTH'(r_entry.addr) : '0;
  assign broad_done_o    = (r_state == ST_RETIRE);
  assign broad_done_id_o = broad_done_o ? BROAD_ID_WIDTH'(r_entry.id) : '0;

`ifdef MESI_ISC_BROAD_ERR_EN
  logic r_invalid;

  always_ff @(posedge clk) begin
    if (w_pop) r_invalid <= !w_head_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= '0;
    end else begin
      if (broad_fifo_wr_i && fifo_status_full_o) err_o[0] <= 1'b1;
      if (r_state == ST_RETIRE && r_invalid)     err_o[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mesi_isc_broad_nc.sv
// Scoreboard bench for mesi_isc_broad_nc: a 4-CPU and an 8-CPU instance share
// the clock and reset; retire tags are checked in order against queued tags.
module tb_mesi_isc_broad_nc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  ack4 = '0;
  logic        wr4 = 1'b0;
  logic [31:0] addr4 = '0;
  logic [1:0]  type4 = '0;
  logic [1:0]  cpu4 = '0;
  logic [4:0]  id4 = '0;
  logic [31:0] caddr4;
  logic [11:0] cmd4w;
  logic        full4, done4, busy4;
  logic [2:0]  cnt4;
  logic [4:0]  did4;

  logic [7:0]  ack8 = '0;
  logic        wr8 = 1'b0;
  logic [31:0] addr8 = '0;
  logic [1:0]  type8 = '0;
  logic [2:0]  cpu8 = '0;
  logic [4:0]  id8 = '0;
  logic [31:0] caddr8;
  logic [23:0] cmd8w;
  logic        full8, done8, busy8;
  logic [3:0]  cnt8;
  logic [4:0]  did8;

`ifdef MESI_ISC_BROAD_ERR_EN
  logic [1:0] err4, err8;
`endif

  mesi_isc_broad_nc u_dut4 (
    .clk(clk), .rst(rst), .cbus_ack_array_i(ack4), .broad_fifo_wr_i(wr4),
    .broad_addr_i(addr4), .broad_type_i(type4), .broad_cpu_id_i(cpu4),
    .broad_id_i(id4), .cbus_addr_o(caddr4), .cbus_cmd_array_o(cmd4w),
    .fifo_status_full_o(full4), .fifo_count_o(cnt4), .broad_done_o(done4),
    .broad_done_id_o(did4), .busy_o(busy4)
`ifdef MESI_ISC_BROAD_ERR_EN
    , .err_o(err4)
`endif
  );

  mesi_isc_broad_nc #(
    .CPU_COUNT(8), .CPU_ID_WIDTH(3), .FIFO_DEPTH(8), .FIFO_DEPTH_LOG2(3)
  ) u_dut8 (
    .clk(clk), .rst(rst), .cbus_ack_array_i(ack8), .broad_fifo_wr_i(wr8),
    .broad_addr_i(addr8), .broad_type_i(type8), .broad_cpu_id_i(cpu8),
    .broad_id_i(id8), .cbus_addr_o(caddr8), .cbus_cmd_array_o(cmd8w),
    .fifo_status_full_o(full8), .fifo_count_o(cnt8), .broad_done_o(done8),
    .broad_done_id_o(did8), .busy_o(busy8)
`ifdef MESI_ISC_BROAD_ERR_EN
    , .err_o(err8)
`endif
  );

  int total = 0;
  int bad = 0;
  int sb4[$];
  int sb8[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] cmd4(input int i);
    return cmd4w[i*3 +: 3];
  endfunction

  function automatic logic [2:0] cmd8(input int i);
    return cmd8w[i*3 +: 3];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] a, input logic [1:0] t, input logic [1:0] c, input logic [4:0] id);
    wr4 = 1'b1; addr4 = a; type4 = t; cpu4 = c; id4 = id;
  endtask

  task automatic push8(input logic [31:0] a, input logic [1:0] t, input logic [2:0] c, input logic [4:0] id);
    wr8 = 1'b1; addr8 = a; type8 = t; cpu8 = c; id8 = id;
  endtask

  // Bounded responder: every CPU acks whatever non-NOP command it sees.
  task automatic drain4(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 4; i++) ack4[i] = (cmd4(i) != 3'd0);
      step();
    end
    ack4 = '0;
  endtask

  task automatic drain8(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 8; i++) ack8[i] = (cmd8(i) != 3'd0);
      step();
    end
    ack8 = '0;
  endtask

  always @(negedge clk) begin
    if (done4) begin
      chk("done4_expected", sb4.size() > 0, 1);
      if (sb4.size() > 0) chk("done4_id", did4, sb4.pop_front());
    end
    if (done8) begin
      chk("done8_expected", sb8.size() > 0, 1);
      if (sb8.size() > 0) chk("done8_id", did8, sb8.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    step(); step();
    chk("rst_cmd4", cmd4w, 0);
    chk("rst_cnt4", cnt4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", {done4, did4}, 0);
    chk("rst_addr4", caddr4, 0);
    chk("rst_full4", full4, 0);
    chk("rst_cmd8", cmd8w, 0);
    chk("rst_busy8", busy8, 0);
    rst = 1'b0;
    step();

    // WR from CPU 2, staggered acks
    push4(32'h100, 2'd1, 2'd2, 5'd5); sb4.push_back(5);
    step(); wr4 = 1'b0;
    chk("wr_cnt_t1", cnt4, 1);
    step();
    chk("wr_snoop0", cmd4(0), 1);
    chk("wr_snoop1", cmd4(1), 1);
    chk("wr_orig_nop", cmd4(2), 0);
    chk("wr_snoop3", cmd4(3), 1);
    chk("wr_addr", caddr4, 32'h100);
    chk("wr_busy", busy4, 1);
    step(); ack4 = 4'b0010;
    chk("wr_cmd1_t3", cmd4(1), 1);
    step(); ack4 = 4'b0000;
    chk("wr_cmd1_nop", cmd4(1), 0);
    chk("wr_cmd0_t4", cmd4(0), 1);
    chk("wr_cmd3_t4", cmd4(3), 1);
    step(); ack4 = 4'b1001;
    step(); ack4 = 4'b0000;
    chk("wr_en_cmds", cmd4w, 12'h3 << 6);
    step(); ack4 = 4'b0100;
    chk("wr_en_hold", cmd4(2), 3);
    step(); ack4 = 4'b0000;
    chk("wr_done", done4, 1);
    chk("wr_done_cmds", cmd4w, 0);
    step();
    chk("wr_idle", {busy4, done4}, 0);
    chk("wr_idle_addr", caddr4, 0);

    // fill FIFO behind a blocked snoop, then push while full with a pop
    push4(32'h200, 2'd1, 2'd0, 5'd10); sb4.push_back(10);
    step(); wr4 = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      push4(32'h300 + 32'(k), 2'd2, 2'(k + 1), 5'(11 + k)); sb4.push_back(11 + k);
      step();
    end
    wr4 = 1'b0;
    chk("fill_full", full4, 1);
    chk("fill_cnt", cnt4, 4);
    chk("fill_blocked", cmd4w, 12'b001_001_001_000);
    ack4 = 4'b1110; step();
    ack4 = 4'b0001; step();
    ack4 = 4'b0000; step();
    chk("pop_idle", busy4, 0);
    push4(32'h999, 2'd1, 2'd1, 5'd31);
    step(); wr4 = 1'b0;
    chk("drop_cnt", cnt4, 3);
    chk("drop_full", full4, 0);
`ifdef MESI_ISC_BROAD_ERR_EN
    chk("err_drop", err4[0], 1);
`endif
    drain4(60);
    chk("fill_drain_cnt", cnt4, 0);
    chk("fill_drain_busy", busy4, 0);
    chk("fill_drain_sb", sb4.size(), 0);

    // RD from CPU 0, all snoop acks in one cycle
    push4(32'h2A0, 2'd2, 2'd0, 5'd7); sb4.push_back(7);
    step(); wr4 = 1'b0;
    step();
    chk("rd_snoops", cmd4w, 12'b010_010_010_000);
    chk("rd_addr", caddr4, 32'h2A0);
    ack4 = 4'b1110;
    step(); ack4 = 4'b0000;
    chk("rd_en", cmd4w, 12'h004);
    ack4 = 4'b0001;
    step(); ack4 = 4'b0000;
    chk("rd_done", {done4, did4}, {1'b1, 5'd7});
    step();
    chk("rd_idle", busy4, 0);

    // invalid type 3
    push4(32'h400, 2'd3, 2'd1, 5'd9); sb4.push_back(9);
    step(); wr4 = 1'b0;
    chk("inv_t1_cmd", cmd4w, 0);
    chk("inv_t1_busy", busy4, 0);
    step();
    chk("inv_t2_cmd", cmd4w, 0);
    chk("inv_t2_done", {done4, did4}, {1'b1, 5'd9});
    step();
    chk("inv_t3", {done4, busy4, cmd4w}, 0);
`ifdef MESI_ISC_BROAD_ERR_EN
    chk("err_inv", err4[1], 1);
`endif

    // reset while in ENABLE aborts the broadcast
    push4(32'h500, 2'd1, 2'd3, 5'd20);
    step(); wr4 = 1'b0;
    step(); ack4 = 4'b0111;
    push4(32'h504, 2'd1, 2'd1, 5'd21);
    step(); ack4 = 4'b0000; wr4 = 1'b0;
    chk("abort_en", cmd4(3), 3);
    chk("abort_cnt_pre", cnt4, 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("abort_cmds", cmd4w, 0);
    chk("abort_cnt", cnt4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    ack4 = 4'b1000;
    step(); ack4 = 4'b0000;
    chk("abort_ack_ign", {busy4, done4, cmd4w}, 0);
    step();
    chk("abort_idle2", {busy4, done4}, 0);
`ifdef MESI_ISC_BROAD_ERR_EN
    chk("err_rst", err4, 0);
`endif

    // 8 CPUs: WR from CPU 7, then two passes of 8 queued requests
    push8(32'h700, 2'd1, 3'd7, 5'd31); sb8.push_back(31);
    step(); wr8 = 1'b0;
    step();
    for (int i = 0; i < 7; i++) chk($sformatf("c8_snoop%0d", i), cmd8(i), 1);
    chk("c8_orig_nop", cmd8(7), 0);
    drain8(20);
    chk("c8_first_sb", sb8.size(), 0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        push8(32'h1000 + 32'(i * 4), 2'(1 + (i % 2)), 3'((i + 3) % 8), 5'(i));
        sb8.push_back(i);
        step();
      end
      wr8 = 1'b0;
      chk($sformatf("c8_cnt_p%0d", pass), cnt8, 7);
      chk($sformatf("c8_full_p%0d", pass), full8, 0);
      drain8(80);
      chk($sformatf("c8_drain_cnt_p%0d", pass), cnt8, 0);
      chk($sformatf("c8_drain_busy_p%0d", pass), busy8, 0);
      chk($sformatf("c8_drain_sb_p%0d", pass), sb8.size(), 0);
    end

    step();
    chk("final_sb4", sb4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
